// File: rtl/btn_press_classifier_pkg.sv
// btn_pkg: shared types and default timing constants for the button press
// classifier.
//   press_state_t    - classifier FSM state encoding
//   LONG_TICKS_DEF   - default hold length (ticks) that makes a long press
//   DCLICK_TICKS_DEF - default release gap (ticks) allowed for a double click
//   max_int          - helper used to size the tick counter ceiling
package btn_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRESS1,
        LONG,
        GAP,
        PRESS2
    } press_state_t;

    localparam int LONG_TICKS_DEF   = 100;
    localparam int DCLICK_TICKS_DEF = 30;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_press_classifier_edge_det.sv
// edge_det: registers a synchronous level and flags its rising and falling
// edges combinationally against the registered copy.
//   clk     - system clock
//   reset   - synchronous, active-high
//   d       - level input, synchronous to clk
//   rise    - d is high now and was low last cycle
//   fall    - d is low now and was high last cycle
// RST_VAL sets the registered copy on reset. Resetting it high means a level
// that is already high when reset releases does not look like a rising edge.
module edge_det #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic rise,
    output logic fall
);

    logic d_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            d_q <= RST_VAL;
        end else begin
            d_q <= d;
        end
    end

    assign rise = d & ~d_q;
    assign fall = ~d & d_q;

endmodule

// File: rtl/btn_press_classifier.sv
// btn_press_classifier: turns the debounced button level into one-cycle
// short_press / long_press / double_click pulses, timing gestures with the
// shared 10 ms tick.
//   clk          - system clock
//   reset        - synchronous, active-high
//   db           - debounced button level
//   tick         - one-cycle strobe every 10 ms
//   short_press  - single press released early, no second press in the gap
//   long_press   - hold reached LONG_TICKS
//   double_click - second press started inside the gap window
//   busy         - FSM is away from IDLE
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for a press
// PRESS1 | first press held, timing toward a long press
// LONG   | long press already reported, waiting for release
// GAP    | first press released, timing the double-click window
// PRESS2 | second press of a double click held, waiting for release
module btn_press_classifier
    import btn_pkg::*;
#(
    parameter int LONG_TICKS   = LONG_TICKS_DEF,
    parameter int DCLICK_TICKS = DCLICK_TICKS_DEF,
    parameter int CW           = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic db,
    input  logic tick,
    output logic short_press,
    output logic long_press,
    output logic double_click,
    output logic busy
);

    localparam logic [CW-1:0] LONG_LAST   = CW'(LONG_TICKS - 1);
    localparam logic [CW-1:0] DCLICK_LAST = CW'(DCLICK_TICKS - 1);
    localparam logic [CW-1:0] CNT_MAX     = CW'(max_int(LONG_TICKS, DCLICK_TICKS) - 1);

    press_state_t  state;
    press_state_t  state_nxt;
    logic [CW-1:0] cnt;
    logic          rise;
    logic          fall;
    logic          short_nxt;
    logic          long_nxt;
    logic          dclick_nxt;

    edge_det #(
        .RST_VAL (1'b1)
    ) u_edge_det (
        .clk   (clk),
        .reset (reset),
        .d     (db),
        .rise  (rise),
        .fall  (fall)
    );

    // Edges take priority over tick timeouts so a release or re-press landing
    // on the same cycle as the deadline still counts as the earlier gesture.
    always_comb begin
        state_nxt  = state;
        short_nxt  = 1'b0;
        long_nxt   = 1'b0;
        dclick_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (rise) begin
                    state_nxt = PRESS1;
                end
            end
            PRESS1: begin
                if (fall) begin
                    state_nxt = GAP;
                end else if (tick && (cnt == LONG_LAST)) begin
                    state_nxt = LONG;
                    long_nxt  = 1'b1;
                end
            end
            LONG: begin
                if (fall) begin
                    state_nxt = IDLE;
                end
            end
            GAP: begin
                if (rise) begin
                    state_nxt  = PRESS2;
                    dclick_nxt = 1'b1;
                end else if (tick && (cnt == DCLICK_LAST)) begin
                    state_nxt = IDLE;
                    short_nxt = 1'b1;
                end
            end
            PRESS2: begin
                if (fall) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            short_press  <= 1'b0;
            long_press   <= 1'b0;
            double_click <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state <= state_nxt;
            // Counter restarts on any state change, so a tick coinciding with
            // a transition is not credited to the new state. It saturates in
            // states that never time out instead of wrapping.
            if (state_nxt != state) begin
                cnt <= '0;
            end else if (tick && (cnt != CNT_MAX)) begin
                cnt <= cnt + CW'(1);
            end
            short_press  <= short_nxt;
            long_press   <= long_nxt;
            double_click <= dclick_nxt;
            busy         <= (state_nxt != IDLE);
        end
    end

endmodule

// File: tb/tb_btn_press_classifier.sv
module tb_btn_press_classifier;

    localparam int LT = 4;
    localparam int DT = 3;

    logic clk;
    logic reset;
    logic db;
    logic tick;
    logic short_press;
    logic long_press;
    logic double_click;
    logic busy;

    btn_press_classifier #(
        .LONG_TICKS   (LT),
        .DCLICK_TICKS (DT),
        .CW           (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .db           (db),
        .tick         (tick),
        .short_press  (short_press),
        .long_press   (long_press),
        .double_click (double_click),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc_n    = 0;
    int phase    = 0;
    int last_drive_edge = 0;
    bit chk_en   = 0;

    // Pulse bookkeeping from the DUT, for the hand-computed pins.
    int n_sp = 0, n_lp = 0, n_dc = 0;
    int sp_edge = 0, lp_edge = 0, dc_edge = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t actual=%0d expected=%0d", name, $time, act, exp);
        end
    endtask

    // Gesture model: how many presses the gesture has seen, whether the button
    // is down, whether the long report was given, and ticks since the last edge.
    int m_presses = 0;
    bit m_down = 0, m_long_done = 0, m_db_prev = 1;
    int m_ticks = 0;
    bit exp_sp = 0, exp_lp = 0, exp_dc = 0, exp_busy = 0;

    always @(posedge clk) begin
        bit r, f;
        cyc_n++;
        exp_sp = 0; exp_lp = 0; exp_dc = 0;
        if (reset) begin
            m_presses = 0; m_down = 0; m_long_done = 0; m_ticks = 0;
            m_db_prev = 1;
        end else begin
            r = db && !m_db_prev;
            f = !db && m_db_prev;
            if (m_presses == 0) begin
                if (r) begin
                    m_presses = 1; m_down = 1; m_long_done = 0; m_ticks = 0;
                end
            end else if (m_presses == 2) begin
                if (f) m_presses = 0;
            end else if (m_long_done) begin
                if (f) m_presses = 0;
            end else if (m_down) begin
                if (f) begin
                    m_down = 0; m_ticks = 0;
                end else if (tick) begin
                    m_ticks++;
                    if (m_ticks == LT) begin
                        m_long_done = 1; exp_lp = 1;
                    end
                end
            end else begin
                if (r) begin
                    m_presses = 2; m_down = 1; exp_dc = 1;
                end else if (tick) begin
                    m_ticks++;
                    if (m_ticks == DT) begin
                        m_presses = 0; exp_sp = 1;
                    end
                end
            end
            m_db_prev = db;
        end
        exp_busy = (m_presses != 0);
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_short",  short_press,  exp_sp);
            chk("cyc_long",   long_press,   exp_lp);
            chk("cyc_dclick", double_click, exp_dc);
            chk("cyc_busy",   busy,         exp_busy);
            chk("cyc_onehot", ((short_press + long_press + double_click) <= 2'd1), 1);
            if (short_press === 1'b1)  begin n_sp++; sp_edge = cyc_n + 1; end
            if (long_press === 1'b1)   begin n_lp++; lp_edge = cyc_n + 1; end
            if (double_click === 1'b1) begin n_dc++; dc_edge = cyc_n + 1; end
        end
    end

    task automatic cyc(input bit dbv);
        db = dbv;
        tick = (phase == 4);
        phase = (phase + 1) % 5;
        last_drive_edge = cyc_n;
        @(posedge clk);
        #2;
    endtask

    task automatic cycles(input int n, input bit dbv);
        for (int i = 0; i < n; i++) cyc(dbv);
    endtask

    task automatic run_to_tick(input int n, input bit dbv, output int tick_edge);
        int cnt;
        bit is_t;
        cnt = 0;
        tick_edge = 0;
        while (cnt < n) begin
            is_t = (phase == 4);
            cyc(dbv);
            if (is_t) begin
                cnt++;
                tick_edge = last_drive_edge;
            end
        end
    endtask

    task automatic pre_tick(input bit dbv);
        while (phase != 4) cyc(dbv);
    endtask

    int s_sp, s_lp, s_dc, t_edge, r_edge, dummy;

    task automatic snap();
        s_sp = n_sp; s_lp = n_lp; s_dc = n_dc;
    endtask

    initial begin
        db = 0; tick = 0; reset = 1;
        cycles(3, 0);
        chk_en = 1;
        reset = 0;
        chk("rst_busy", busy, 0);
        chk("rst_pulses", {short_press, long_press, double_click}, 0);
        cycles(3, 0);

        // Short press: released early, gap expires on the 3rd gap tick.
        snap();
        cycles(10, 1);
        cyc(0);
        run_to_tick(3, 0, t_edge);
        cycles(20, 0);
        chk("short_cnt_sp", n_sp - s_sp, 1);
        chk("short_cnt_other", (n_lp - s_lp) + (n_dc - s_dc), 0);
        chk("short_latency", sp_edge - t_edge, 2);
        chk("short_busy_end", busy, 0);

        // Long press: reported on the 4th hold tick, nothing on release.
        snap();
        cyc(1);
        run_to_tick(4, 1, t_edge);
        cycles(30, 1);
        chk("long_busy_held", busy, 1);
        cyc(0);
        chk("long_busy_fall", busy, 0);
        cycles(10, 0);
        chk("long_cnt_lp", n_lp - s_lp, 1);
        chk("long_cnt_other", (n_sp - s_sp) + (n_dc - s_dc), 0);
        chk("long_latency", lp_edge - t_edge, 2);

        // Double click.
        snap();
        cycles(10, 1);
        cycles(7, 0);
        cyc(1);
        r_edge = last_drive_edge;
        cycles(9, 1);
        cycles(10, 0);
        chk("dbl_cnt_dc", n_dc - s_dc, 1);
        chk("dbl_cnt_other", (n_sp - s_sp) + (n_lp - s_lp), 0);
        chk("dbl_latency", dc_edge - r_edge, 2);
        chk("dbl_busy_end", busy, 0);

        // Second rise lands on the 3rd gap tick: double click wins.
        snap();
        cycles(6, 1);
        cyc(0);
        run_to_tick(2, 0, dummy);
        pre_tick(0);
        cyc(1);
        chk("gapA_dc_now", double_click, 1);
        cycles(3, 1);
        cycles(10, 0);
        chk("gapA_cnt_dc", n_dc - s_dc, 1);
        chk("gapA_cnt_sp", n_sp - s_sp, 0);

        // Rise one cycle after the 3rd gap tick: short, then a new press.
        snap();
        cycles(6, 1);
        cyc(0);
        run_to_tick(3, 0, t_edge);
        chk("gapB_sp_now", short_press, 1);
        chk("gapB_busy_idle", busy, 0);
        cyc(1);
        chk("gapB_busy_new", busy, 1);
        chk("gapB_no_dc", double_click, 0);
        cycles(3, 1);
        cyc(0);
        run_to_tick(3, 0, dummy);
        cycles(5, 0);
        chk("gapB_cnt_sp", n_sp - s_sp, 2);
        chk("gapB_cnt_dc", n_dc - s_dc, 0);

        // Release on the 4th hold tick: fall wins, resolves as short.
        snap();
        cyc(1);
        run_to_tick(3, 1, dummy);
        pre_tick(1);
        cyc(0);
        run_to_tick(3, 0, dummy);
        cycles(5, 0);
        chk("lbnd_cnt_lp", n_lp - s_lp, 0);
        chk("lbnd_cnt_sp", n_sp - s_sp, 1);

        // Reset while in the gap window.
        snap();
        cycles(6, 1);
        cyc(0);
        cycles(2, 0);
        chk("rgap_busy_before", busy, 1);
        reset = 1;
        cyc(0);
        reset = 0;
        chk("rgap_busy_after", busy, 0);
        cycles(20, 0);
        chk("rgap_no_events", (n_sp - s_sp) + (n_lp - s_lp) + (n_dc - s_dc), 0);

        // Button held through reset release: ignored until released and re-pressed.
        snap();
        cycles(3, 1);
        reset = 1;
        cycles(2, 1);
        reset = 0;
        cycles(30, 1);
        chk("rheld_busy", busy, 0);
        chk("rheld_no_events", (n_sp - s_sp) + (n_lp - s_lp) + (n_dc - s_dc), 0);
        cyc(0);
        cycles(3, 0);
        chk("rheld_busy_rel", busy, 0);
        cyc(1);
        chk("rheld_busy_press", busy, 1);
        cycles(3, 1);
        cyc(0);
        run_to_tick(3, 0, dummy);
        cycles(5, 0);
        chk("rheld_cnt_sp", n_sp - s_sp, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
